// File: rtl/stim_seq.sv
// stim_seq: stimulus sequencer for the balance-platform bench and self-test.
// Holds DEPTH entries, each with NUM_CH channel values, an optional command
// byte and a hold count. The entries are played out in order on start.
// Optional feature: define STIM_LOOP_EN to add the loop and stop inputs.
// With loop=1, playback repeats until stop ends it at an entry boundary.
module stim_seq #(
    parameter int                NUM_CH    = 6,
    parameter int                DW        = 12,
    parameter int                DEPTH     = 16,
    parameter int                HOLD_W    = 16,
    parameter int                CMD_W     = 8,
    parameter int                CMD_PULSE = 2,
    parameter logic [NUM_CH-1:0] MID_MASK  = 6'b000100
) (
    input  logic                       clk,
    input  logic                       RST,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [NUM_CH*DW-1:0]       wr_vals,
    input  logic [CMD_W-1:0]           wr_cmd,
    input  logic                       wr_cmd_vld,
    input  logic [HOLD_W-1:0]          wr_hold,
    input  logic [$clog2(DEPTH):0]     num_entries,
    input  logic                       start,
`ifdef STIM_LOOP_EN
    input  logic                       loop,
    input  logic                       stop,
`endif
    output logic [NUM_CH*DW-1:0]       ch_out,
    output logic [CMD_W-1:0]           cmd,
    output logic                       send_cmd,
    output logic                       busy,
    output logic                       done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = (CMD_PULSE > 1) ? $clog2(CMD_PULSE) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_CMD,
        S_HOLD,
        S_FIN
    } state_t;

    // Channel bus value after reset: mid-scale on MID_MASK channels, else 0.
    function automatic logic [NUM_CH*DW-1:0] reset_vals();
        logic [NUM_CH*DW-1:0] v;
        v = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (MID_MASK[k]) begin
                v[k*DW +: DW] = {1'b1, {(DW-1){1'b0}}};
            end
        end
        return v;
    endfunction

    // Entry storage (never reset; contents survive RST)
    logic [NUM_CH*DW-1:0] mem_vals [DEPTH];
    logic [CMD_W-1:0]     mem_cmd  [DEPTH];
    logic                 mem_vld  [DEPTH];
    logic [HOLD_W-1:0]    mem_hold [DEPTH];

    state_t              state;
    logic [AW-1:0]       ptr;
    logic [CW-1:0]       count;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [PW-1:0]       pulse_cnt;
    logic                cur_vld;

    logic [AW-1:0]        fetch_idx;
    logic [NUM_CH*DW-1:0] f_vals;
    logic [CMD_W-1:0]     f_cmd;
    logic                 f_vld;
    logic [HOLD_W-1:0]    f_hold;
    logic [CW-1:0]        count_in;
    logic                 last_entry;
    logic                 entry_end;
    logic                 finish;

    // Store an entry; only accepted while the sequencer is idle.
    always_ff @(posedge clk) begin
        if (wr_en && state == S_IDLE) begin
            mem_vals[wr_addr] <= wr_vals;
            mem_cmd[wr_addr]  <= wr_cmd;
            mem_vld[wr_addr]  <= wr_cmd_vld;
            mem_hold[wr_addr] <= wr_hold;
        end
    end

    // Requested entry count, clamped to the storage depth.
    assign count_in = (num_entries > CW'(DEPTH)) ? CW'(DEPTH) : num_entries;

    // The entry being played is the last one of the sequence.
    assign last_entry = ({1'b0, ptr} == count - CW'(1));

    // Final cycle of the current entry: no command pulse or hold left.
    assign entry_end = (state == S_APPLY && !cur_vld && hold_cnt == '0) ||
                       (state == S_CMD && pulse_cnt == '0 && hold_cnt == '0) ||
                       (state == S_HOLD && hold_cnt == HOLD_W'(1));

`ifdef STIM_LOOP_EN
    logic loop_q;
    logic stop_req;

    // Loop mode is latched on start; a stop request is held until playback ends.
    always_ff @(posedge clk) begin
        if (RST) begin
            loop_q   <= 1'b0;
            stop_req <= 1'b0;
        end else if (state == S_IDLE) begin
            stop_req <= 1'b0;
            if (start) begin
                loop_q <= loop;
            end
        end else if (stop) begin
            stop_req <= 1'b1;
        end
    end

    assign finish = stop_req || stop || (last_entry && !loop_q);
`else
    assign finish = last_entry;
`endif

    // Select the next entry to load, forwarding a same-cycle write from idle.
    always_comb begin
        fetch_idx = (state == S_IDLE || last_entry) ? '0 : ptr + AW'(1);
        f_vals    = mem_vals[fetch_idx];
        f_cmd     = mem_cmd[fetch_idx];
        f_vld     = mem_vld[fetch_idx];
        f_hold    = mem_hold[fetch_idx];
        if (state == S_IDLE && wr_en && wr_addr == fetch_idx) begin
            f_vals = wr_vals;
            f_cmd  = wr_cmd;
            f_vld  = wr_cmd_vld;
            f_hold = wr_hold;
        end
    end

    // Playback FSM; every output is registered on the transition into its state.
    always_ff @(posedge clk) begin
        if (RST) begin
            state     <= S_IDLE;
            ptr       <= '0;
            count     <= '0;
            hold_cnt  <= '0;
            pulse_cnt <= '0;
            cur_vld   <= 1'b0;
            ch_out    <= reset_vals();
            cmd       <= '0;
            send_cmd  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (entry_end) begin
            send_cmd <= 1'b0;
            if (finish) begin
                state <= S_FIN;
                done  <= 1'b1;
            end else begin
                state    <= S_APPLY;
                ptr      <= fetch_idx;
                ch_out   <= f_vals;
                cur_vld  <= f_vld;
                hold_cnt <= f_hold;
                if (f_vld) begin
                    cmd <= f_cmd;
                end
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (num_entries == '0) begin
                            state <= S_FIN;
                            done  <= 1'b1;
                        end else begin
                            state    <= S_APPLY;
                            count    <= count_in;
                            ptr      <= fetch_idx;
                            ch_out   <= f_vals;
                            cur_vld  <= f_vld;
                            hold_cnt <= f_hold;
                            if (f_vld) begin
                                cmd <= f_cmd;
                            end
                        end
                    end
                end
                S_APPLY: begin
                    if (cur_vld) begin
                        state     <= S_CMD;
                        send_cmd  <= 1'b1;
                        pulse_cnt <= PW'(CMD_PULSE - 1);
                    end else begin
                        state <= S_HOLD;
                    end
                end
                S_CMD: begin
                    if (pulse_cnt == '0) begin
                        state    <= S_HOLD;
                        send_cmd <= 1'b0;
                    end else begin
                        pulse_cnt <= pulse_cnt - PW'(1);
                    end
                end
                S_HOLD: begin
                    hold_cnt <= hold_cnt - HOLD_W'(1);
                end
                S_FIN: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
